// File: rtl/strobe_delay_multi_pkg.sv
// strobe_delay_multi: shared types and helpers.
// Edge-mode encoding and delay clamping used by top and channels.
package strobe_delay_pkg;

  typedef enum logic [1:0] {
    EM_RISE = 2'b00,
    EM_FALL = 2'b01,
    EM_BOTH = 2'b10
  } edge_mode_t;

  // Zero means one cycle; anything past the chain length saturates.
  function automatic int unsigned clamp_dly(
    input int unsigned d,
    input int unsigned max_d
  );
    if (d == 0) return 1;
    else if (d > max_d) return max_d;
    else return d;
  endfunction

  // The reserved code 11 behaves as rise.
  function automatic edge_mode_t decode_mode(input logic [1:0] m);
    edge_mode_t r;
    unique case (m)
      2'b01:   r = EM_FALL;
      2'b10:   r = EM_BOTH;
      default: r = EM_RISE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/strobe_delay_multi_if.sv
// strobe_delay_multi: config, strobe and status bundle.
// master drives config and raw strobes; slave returns pulses.
interface strobe_delay_multi_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DLY_W = 4,
  parameter int unsigned PW_W  = 4
);
  logic             en;
  logic [DLY_W-1:0] dly_cfg;
  logic [1:0]       edge_mode;
  logic [PW_W-1:0]  pw_cfg;
  logic [N_CH-1:0]  strob_in;
  logic [N_CH-1:0]  strob_main;
  logic             busy;

  modport master (
    output en, dly_cfg, edge_mode, pw_cfg, strob_in,
    input  strob_main, busy
  );

  modport slave (
    input  en, dly_cfg, edge_mode, pw_cfg, strob_in,
    output strob_main, busy
  );
endinterface

// File: rtl/strobe_delay_multi_ch.sv
// strobe_delay_ch: one strobe channel.
// Delay chain, tap mux, edge detect and retriggerable stretcher.
module strobe_delay_ch
  import strobe_delay_pkg::*;
#(
  parameter int unsigned MAX_DELAY = 8,
  parameter int unsigned DLY_W     = 4,
  parameter int unsigned PW_W      = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [DLY_W-1:0] dly,
  input  edge_mode_t       mode,
  input  logic [PW_W-1:0]  pw,
  input  logic             strob_in,
  output logic             strob_main
);

  // chain[i] holds the input as sampled i+1 edges ago.
  logic [MAX_DELAY:0] chain;
  logic               tap;
  logic               prev;
  logic               rise;
  logic               fall;
  logic               ev;
  logic [PW_W-1:0]    cnt;

  // Shift register runs whenever not in reset, even with en low.
  always_ff @(posedge clk) begin
    if (clr) chain <= '0;
    else     chain <= {chain[MAX_DELAY-1:0], strob_in};
  end

  // Select the delayed sample and the one just behind it.
  always_comb begin
    tap  = 1'b0;
    prev = 1'b0;
    for (int i = 1; i <= int'(MAX_DELAY); i++) begin
      if (dly == DLY_W'(i)) begin
        tap  = chain[i-1];
        prev = chain[i];
      end
    end
  end

  assign rise = tap & ~prev;
  assign fall = ~tap & prev;

  // Pick the event for the configured edge mode.
  always_comb begin
    ev = rise;
    unique case (1'b1)
      (mode == EM_FALL): ev = fall;
      (mode == EM_BOTH): ev = rise | fall;
      default:           ev = rise;
    endcase
  end

  // Stretch counter: reload on event, count down otherwise.
  always_ff @(posedge clk) begin
    if (clr || !en)    cnt <= '0;
    else if (ev)       cnt <= pw - PW_W'(1);
    else if (cnt != 0) cnt <= cnt - PW_W'(1);
  end

  assign strob_main = en & (ev | (cnt != '0));

endmodule

// File: rtl/strobe_delay_multi.sv
// strobe_delay_multi: N-channel strobe delay and edge stretcher.
// Latches shared config while disabled; fans out to channels.
module strobe_delay_multi
  import strobe_delay_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MAX_DELAY = 8,
  parameter int unsigned PW_W      = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  strobe_delay_multi_if.slave bus
);

  localparam int unsigned DLY_W = $clog2(MAX_DELAY + 1);

  logic [DLY_W-1:0] dly;
  edge_mode_t       mode;
  logic [PW_W-1:0]  pw;
  logic [DLY_W-1:0] dly_in;
  logic [PW_W-1:0]  pw_in;
  logic [N_CH-1:0]  main_vec;

  assign dly_in = DLY_W'(clamp_dly(32'(bus.dly_cfg), MAX_DELAY));
  assign pw_in  = (bus.pw_cfg == '0) ? PW_W'(1) : bus.pw_cfg;

  // Config is captured only while disabled, held while running.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      dly  <= DLY_W'(1);
      mode <= EM_RISE;
      pw   <= PW_W'(1);
    end else if (!bus.en) begin
      dly  <= dly_in;
      mode <= decode_mode(bus.edge_mode);
      pw   <= pw_in;
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    strobe_delay_ch #(
      .MAX_DELAY (MAX_DELAY),
      .DLY_W     (DLY_W),
      .PW_W      (PW_W)
    ) u_ch (
      .clk        (CLK),
      .clr        (CLR),
      .en         (bus.en),
      .dly        (dly),
      .mode       (mode),
      .pw         (pw),
      .strob_in   (bus.strob_in[g]),
      .strob_main (main_vec[g])
    );
  end

  assign bus.strob_main = main_vec;
  assign bus.busy       = |main_vec;

endmodule

// File: tb/tb_strobe_delay_multi.sv
// tb_strobe_delay_multi: directed vector bench.
// Rows apply inputs, clock one edge, then check outputs.
module tb_strobe_delay_multi;

  logic clk;
  logic clr;

  strobe_delay_multi_if #(.N_CH(4), .DLY_W(4), .PW_W(4)) bus ();

  strobe_delay_multi #(
    .N_CH      (4),
    .MAX_DELAY (8),
    .PW_W      (4)
  ) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic [3:0] dly;
    logic [1:0] mode;
    logic [3:0] pw;
    logic [3:0] sin;
    logic [3:0] exp;
    int         phase;
  } vec_t;

  vec_t       vq[$];
  int         total;
  int         bad;
  int         phase;
  logic [3:0] c_dly;
  logic [1:0] c_mode;
  logic [3:0] c_pw;

  function automatic void push(
    input logic c, input logic e, input logic [3:0] d,
    input logic [1:0] m, input logic [3:0] p,
    input logic [3:0] s, input logic [3:0] x
  );
    vec_t v;
    v.clr = c; v.en = e; v.dly = d; v.mode = m;
    v.pw = p; v.sin = s; v.exp = x; v.phase = phase;
    vq.push_back(v);
  endfunction

  function automatic void r(input logic [3:0] s, input logic [3:0] x);
    push(1'b0, 1'b1, c_dly, c_mode, c_pw, s, x);
  endfunction

  // New phase: load config with en low and flush the chain.
  function automatic void cfg(
    input logic [3:0] d, input logic [1:0] m, input logic [3:0] p
  );
    phase++;
    c_dly = d; c_mode = m; c_pw = p;
    for (int i = 0; i < 10; i++)
      push(1'b0, 1'b0, d, m, p, 4'h0, 4'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] x);
    total++;
    if (bus.strob_main !== x || bus.busy !== (|x)) begin
      bad++;
      $display("FAIL %s: strob_main=%h busy=%b want %h/%b",
               nm, bus.strob_main, bus.busy, x, |x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; phase = 0;
    clr = 1'b1;
    bus.en = 1'b0; bus.dly_cfg = 4'd2; bus.edge_mode = 2'b00;
    bus.pw_cfg = 4'd1; bus.strob_in = 4'h0;

    // reset rows, strobes high must not leak
    push(1'b1, 1'b0, 4'd2, 2'b00, 4'd1, 4'hF, 4'h0);
    push(1'b1, 1'b0, 4'd2, 2'b00, 4'd1, 4'hF, 4'h0);

    // legacy: D=2, rise, pw=1
    cfg(4'd2, 2'b00, 4'd1);
    r(4'h1, 4'h0); r(4'h1, 4'h1); r(4'h1, 4'h0);
    r(4'h0, 4'h0); r(4'h0, 4'h0); r(4'h0, 4'h0);
    // dly_cfg changed while enabled: latency stays 2
    push(1'b0, 1'b1, 4'd6, 2'b00, 4'd1, 4'h1, 4'h0);
    push(1'b0, 1'b1, 4'd6, 2'b00, 4'd1, 4'h0, 4'h1);
    push(1'b0, 1'b1, 4'd6, 2'b00, 4'd1, 4'h0, 4'h0);
    push(1'b0, 1'b1, 4'd6, 2'b00, 4'd1, 4'h0, 4'h0);

    // dly 0 behaves as 1
    cfg(4'd0, 2'b00, 4'd1);
    r(4'h4, 4'h4); r(4'h4, 4'h0); r(4'h0, 4'h0); r(4'h0, 4'h0);

    // dly 15 clamps to 8
    cfg(4'd15, 2'b00, 4'd1);
    r(4'h8, 4'h0);
    for (int i = 0; i < 6; i++) r(4'h0, 4'h0);
    r(4'h0, 4'h8); r(4'h0, 4'h0); r(4'h0, 4'h0);

    // D=3: all channels at once, then staggered
    cfg(4'd3, 2'b00, 4'd1);
    r(4'hF, 4'h0); r(4'h0, 4'h0); r(4'h0, 4'hF); r(4'h0, 4'h0);
    r(4'h0, 4'h0);
    r(4'h1, 4'h0); r(4'h2, 4'h0); r(4'h0, 4'h1); r(4'h0, 4'h2);
    r(4'h0, 4'h0);

    // both edges
    cfg(4'd2, 2'b10, 4'd1);
    r(4'h2, 4'h0); r(4'h2, 4'h2); r(4'h2, 4'h0); r(4'h2, 4'h0);
    r(4'h0, 4'h0); r(4'h0, 4'h2); r(4'h0, 4'h0); r(4'h0, 4'h0);

    // fall only
    cfg(4'd2, 2'b01, 4'd1);
    r(4'h2, 4'h0); r(4'h2, 4'h0); r(4'h2, 4'h0); r(4'h2, 4'h0);
    r(4'h0, 4'h0); r(4'h0, 4'h2); r(4'h0, 4'h0); r(4'h0, 4'h0);

    // reserved mode acts as rise
    cfg(4'd2, 2'b11, 4'd1);
    r(4'h2, 4'h0); r(4'h2, 4'h2); r(4'h2, 4'h0); r(4'h2, 4'h0);
    r(4'h0, 4'h0); r(4'h0, 4'h0); r(4'h0, 4'h0); r(4'h0, 4'h0);

    // pw=5 single rise: 5 cycles
    cfg(4'd2, 2'b00, 4'd5);
    r(4'h1, 4'h0);
    for (int i = 0; i < 5; i++) r(4'h0, 4'h1);
    r(4'h0, 4'h0); r(4'h0, 4'h0);
    // retrigger 3 apart: 8 contiguous cycles
    r(4'h1, 4'h0); r(4'h0, 4'h1); r(4'h0, 4'h1); r(4'h1, 4'h1);
    for (int i = 0; i < 5; i++) r(4'h0, 4'h1);
    r(4'h0, 4'h0); r(4'h0, 4'h0);
    // en dropped mid-pulse, no stale pulse after
    r(4'h1, 4'h0); r(4'h0, 4'h1); r(4'h0, 4'h1);
    push(1'b0, 1'b0, 4'd2, 2'b00, 4'd5, 4'h0, 4'h0);
    r(4'h0, 4'h0); r(4'h0, 4'h0); r(4'h0, 4'h0);

    // pw 0 behaves as 1
    cfg(4'd2, 2'b00, 4'd0);
    r(4'h1, 4'h0); r(4'h0, 4'h1); r(4'h0, 4'h0); r(4'h0, 4'h0);

    // reset in 3rd cycle of a pw=5 pulse, input held high
    cfg(4'd2, 2'b00, 4'd5);
    r(4'h1, 4'h0); r(4'h1, 4'h1); r(4'h1, 4'h1); r(4'h1, 4'h1);
    push(1'b1, 1'b1, 4'd2, 2'b00, 4'd5, 4'h1, 4'h0);
    push(1'b1, 1'b1, 4'd2, 2'b00, 4'd5, 4'h1, 4'h0);
    // config back to D=1, pw=1 after reset
    r(4'h1, 4'h1); r(4'h1, 4'h0); r(4'h0, 4'h0); r(4'h0, 4'h0);

    foreach (vq[i]) begin
      clr           = vq[i].clr;
      bus.en        = vq[i].en;
      bus.dly_cfg   = vq[i].dly;
      bus.edge_mode = vq[i].mode;
      bus.pw_cfg    = vq[i].pw;
      bus.strob_in  = vq[i].sin;
      tick();
      check($sformatf("vec p%0d r%0d", vq[i].phase, i), vq[i].exp);
    end

    // en drop seen combinationally in the same cycle
    clr = 1'b0;
    bus.en = 1'b0; bus.dly_cfg = 4'd2; bus.edge_mode = 2'b00;
    bus.pw_cfg = 4'd5; bus.strob_in = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    bus.en = 1'b1;
    bus.strob_in = 4'h2;
    tick();
    check("en_seq idle", 4'h0);
    bus.strob_in = 4'h0;
    tick();
    check("en_seq event", 4'h2);
    tick();
    check("en_seq stretch", 4'h2);
    bus.en = 1'b0;
    #1;
    check("en_seq drop", 4'h0);
    tick();
    check("en_seq off", 4'h0);
    bus.en = 1'b1;
    tick();
    check("en_seq reen1", 4'h0);
    tick();
    check("en_seq reen2", 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/strobe_delay_multi.md
Name: strobe_delay_multi

Overview:
- Parametrised N-channel successor of the fixed two-stage strobe delay/edge detector.
- Each channel delays its input strobe by a programmable 1..MAX_DELAY cycles and detects a selectable edge (rise/fall/both) on the delayed signal.
- Each detected edge produces an output pulse stretched to a programmable width, with retrigger.
- Sits between the bus RW/RD strobe sources and the main-strobe consumers; one instance serves all strobe channels.

Parameters:
- N_CH, 4: number of independent strobe channels.
- MAX_DELAY, 8: maximum programmable delay in cycles (>=1).
- PW_W, 4: width of the pulse-width config field. Maximum pulse is 2^PW_W-1 cycles.
- DLY_W, $clog2(MAX_DELAY+1): width of the delay config field (derived, not overridden).

Ports:
- CLK, in, 1: single clock, rising edge.
- CLR, in, 1: synchronous active-high reset.
- en, in, 1: global enable. 0 forces outputs low and loads config.
- dly_cfg, in, DLY_W: delay in cycles. 0 is treated as 1; values >MAX_DELAY clamp to MAX_DELAY.
- edge_mode, in, 2: 00 = rise, 01 = fall, 10 = both, 11 = rise (reserved).
- pw_cfg, in, PW_W: output pulse width in cycles. 0 is treated as 1.
- strob_in, in, N_CH: raw strobe per channel.
- strob_main, out, N_CH: delayed, edge-detected, stretched pulse per channel.
- busy, out, 1: OR of all channel pulse-active flags.

Behaviour:
- Clock and reset: one clock, CLK. Reset CLR is synchronous, active-high, and overrides everything on the same edge.
- Reset state:
  - All chain bits and stretch counters are 0.
  - Latched config: dly=1, mode=rise, pw=1.
  - strob_main=0 and busy=0 from the first edge with CLR=1, and until a new edge arrives after CLR falls.
- Delay chain:
  - Per channel, MAX_DELAY+1 registers: d[1]<=strob_in, d[k]<=d[k-1].
  - The chain shifts whenever CLR=0, regardless of en.
- Tap selection: tap=d[D], prev=d[D+1], where D is the latched, clamped delay.
- Edge events:
  - rise=tap&!prev; fall=!tap&prev; both=rise|fall.
  - With D=2 and pw=1 this is identical to the legacy behaviour: strob_in sampled high at edge k gives strob_main high for exactly the cycle after edge k+1.
- Latency: an input edge sampled at CLK edge k yields strob_main high in the cycle after edge k+D-1. strob_main is combinational from registers, with no extra output flop.
- Stretch: per-channel counter cnt (PW_W bits).
  - strob_main = en & (event | cnt!=0).
  - On event: cnt<=pw-1.
  - Else if cnt!=0: cnt<=cnt-1.
  - Retrigger: an event while cnt!=0 reloads cnt to pw-1, so the pulse extends with no gap.
  - Result: a single event gives exactly pw high cycles. Two events spaced s<pw cycles apart give s+pw contiguous high cycles.
- Config latching:
  - dly_cfg, edge_mode and pw_cfg are registered into latched config on every edge where en=0 and CLR=0.
  - Config is held constant while en=1; changes on the input ports while en=1 are ignored.
- Enable:
  - en=0: strob_main=0, busy=0, all cnt<=0.
  - Events occurring while en=0 are discarded, including the cycle en rises. The first event that can register is the one evaluated on the first edge with en=1.
- Reset mid-pulse: CLR clears cnt and the chain on the same edge. No residual pulse and no spurious edge after CLR falls; the chain restarts all-zero, so a strob_in held high produces a rise event D cycles later.
- Channel independence: channels share config only. Simultaneous events on all channels are handled independently.
- busy = OR over channels of strob_main.

Decomposition:
- Package strobe_delay_pkg holds:
  - typedef edge_mode_t enum {EM_RISE=2'b00, EM_FALL=2'b01, EM_BOTH=2'b10}.
  - Function clamp_dly(DLY_W input) returning 1..MAX_DELAY.
- Sub-module strobe_delay_ch is one channel: chain, tap mux, edge detect and stretch counter, with latched config as inputs. The top level holds config latching and busy, and instantiates N_CH channels in a generate loop.

Test Plan:
- Reset/legacy: CLR=1 for 2 cycles, then en=0 with dly=2, mode=rise, pw=1, then en=1. A 3-cycle high pulse on strob_in[0] sampled at edge 10 -> strob_main[0] high only in the cycle after edge 11; other channels stay 0; busy mirrors it.
- Delay/clamp: dly_cfg=0 -> output in the cycle after edge k (D=1). dly_cfg=15 with MAX_DELAY=8 -> output in the cycle after edge k+7.
- Mode: mode=both, pw=1, strob_in[1] high for 4 cycles -> two 1-cycle pulses spaced 4 cycles apart. mode=fall -> only the second pulse.
- Stretch/retrigger: pw=5 with a single rise -> exactly 5 high cycles. Two rises 3 cycles apart (toggle input) -> 8 contiguous high cycles.
- Config hold and enable: change dly_cfg while en=1 -> latency unchanged. Drop en mid-pulse -> strob_main=0 the same cycle and cnt cleared; re-enable -> no stale pulse.
- Reset mid-operation: assert CLR during the 3rd cycle of a pw=5 pulse -> strob_main=0 at the next edge. Release CLR with strob_in still high -> a fresh pulse D cycles after release.
